// File: rtl/icache_line_fill_if.sv
// rtl/icache_line_fill_if.sv - backing-memory word read bus for the icache line-fill engine
interface icache_line_fill_if #(
  parameter int ADDR_W = 20,
  parameter int WORD_W = 32
);
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_rdata_i;
  logic              mem_rvalid_i;

  modport master (
    output mem_rd_o,
    output mem_addr_o,
    input  mem_rdata_i,
    input  mem_rvalid_i
  );

  modport slave (
    input  mem_rd_o,
    input  mem_addr_o,
    output mem_rdata_i,
    output mem_rvalid_i
  );
endinterface

// File: rtl/icache_line_fill.sv
// rtl/icache_line_fill.sv - fetches one cache line as sequential single-outstanding word reads
module icache_line_fill #(
  parameter  int ADDR_W = 20,
  parameter  int WORD_W = 32,
  parameter  int WORDS  = 4,
  localparam int LINE_W = WORD_W * WORDS
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic                rqst_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                cancel_i,
  icache_line_fill_if.master  mem,
  output logic                data_ready_o,
  output logic [LINE_W-1:0]   line_o,
  output logic [ADDR_W-1:0]   line_addr_o,
  output logic                busy_o
);

  localparam int BEAT_W   = $clog2(WORDS);
  localparam int WORD_OFF = $clog2(WORD_W / 8);
  localparam int LINE_OFF = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [ADDR_W-1:0]   base_q;
  logic [LINE_W-1:0]   line_q;
  logic [ADDR_W-1:0]   line_addr_q;
  logic                last_beat;
  logic                accept;
  logic                word_take;
  logic [ADDR_W-1:0]   word_off;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^addr_i[LINE_OFF-1:0];

  assign last_beat = (beat_q == BEAT_W'(WORDS - 1));
  assign accept    = (state_q == S_IDLE) && rqst_i;
  // A cancelled beat drops its word even if the data arrives in the same cycle.
  assign word_take = (state_q == S_WAIT) && mem.mem_rvalid_i && !cancel_i;
  assign word_off  = {{(ADDR_W - BEAT_W - WORD_OFF){1'b0}}, beat_q, {WORD_OFF{1'b0}}};

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rqst_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = cancel_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (cancel_i) begin
          state_d = mem.mem_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (mem.mem_rvalid_i) begin
          state_d = last_beat ? S_RESP : S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (mem.mem_rvalid_i) state_d = S_IDLE;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem.mem_rd_o   = 1'b0;
    mem.mem_addr_o = '0;
    data_ready_o   = 1'b0;
    busy_o         = (state_q != S_IDLE);
    if (state_q == S_ISSUE) begin
      mem.mem_rd_o   = 1'b1;
      mem.mem_addr_o = base_q + word_off;
    end
    if (state_q == S_RESP) begin
      data_ready_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      beat_q      <= '0;
      base_q      <= '0;
      line_q      <= '0;
      line_addr_q <= '0;
    end else begin
      if (accept) begin
        base_q <= {addr_i[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
        beat_q <= '0;
      end
      if (word_take) begin
        for (int k = 0; k < WORDS; k++) begin
          if (beat_q == BEAT_W'(k)) begin
            line_q[k*WORD_W +: WORD_W] <= mem.mem_rdata_i;
          end
        end
        // The beat counter parks on the last word; the next accept clears it.
        if (last_beat) begin
          line_addr_q <= base_q;
        end else begin
          beat_q <= beat_q + BEAT_W'(1);
        end
      end
    end
  end

  assign line_o      = line_q;
  assign line_addr_o = line_addr_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// tb/tb_icache_line_fill.sv - randomized self-checking bench for icache_line_fill
module tb_icache_line_fill;

  logic          clk = 1'b0;
  logic          rsn = 1'b0;
  logic          rqst = 1'b0;
  logic          cancel = 1'b0;
  logic [19:0]   addr = '0;
  logic          dr;
  logic [127:0]  line;
  logic [19:0]   line_addr;
  logic          busy;

  int tests_run = 0;
  int tests_failed = 0;
  int lat = 1;
  int pending = 0;
  int dr_cnt = 0;
  logic [19:0] rd_addr_q[$];
  logic [31:0] rd_data_q[$];

  icache_line_fill_if #(.ADDR_W(20), .WORD_W(32)) mem_if ();

  icache_line_fill dut (
    .clk_i        (clk),
    .rsn_i        (rsn),
    .rqst_i       (rqst),
    .addr_i       (addr),
    .cancel_i     (cancel),
    .mem          (mem_if),
    .data_ready_o (dr),
    .line_o       (line),
    .line_addr_o  (line_addr),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: data returns exactly lat cycles after the read strobe cycle.
  initial begin
    mem_if.mem_rvalid_i = 1'b0;
    mem_if.mem_rdata_i  = '0;
    forever begin
      @(posedge clk or negedge rsn);
      if (!rsn) begin
        pending = 0;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = '0;
      end else begin
        #1;
        mem_if.mem_rvalid_i = 1'b0;
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            mem_if.mem_rdata_i  = $urandom;
            mem_if.mem_rvalid_i = 1'b1;
            rd_data_q.push_back(mem_if.mem_rdata_i);
          end
        end
        if (mem_if.mem_rd_o) begin
          chk("one_outstanding", 128'(pending), 128'd0);
          rd_addr_q.push_back(mem_if.mem_addr_o);
          pending = lat;
        end
      end
    end
  end

  always @(negedge clk) if (dr) dr_cnt++;

  task automatic start_req(input logic [19:0] a, input int l);
    lat = l;
    rd_addr_q.delete();
    rd_data_q.delete();
    @(negedge clk);
    rqst = 1'b1;
    addr = a;
    @(negedge clk);
    rqst = 1'b0;
  endtask

  task automatic wait_reads(input int cnt);
    int n = 0;
    while (rd_addr_q.size() < cnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reads_reached", 128'(rd_addr_q.size()), 128'(cnt));
  endtask

  task automatic run_fill(input logic [19:0] a, input int l, input bit noisy);
    int n;
    int dr0;
    logic [19:0]  base;
    logic [127:0] exp_line;
    dr0 = dr_cnt;
    start_req(a, l);
    n = 1;
    while (!dr && n < 200) begin
      if (noisy) begin
        rqst = 1'($urandom_range(0, 1));
        addr = 20'h00500;
      end
      @(negedge clk);
      n++;
    end
    rqst = 1'b0;
    base = {a[19:4], 4'h0};
    chk("latency", 128'(n), 128'(4 * (l + 1) + 1));
    chk("line_addr", 128'(line_addr), 128'(base));
    chk("read_count", 128'(rd_addr_q.size()), 128'd4);
    exp_line = '0;
    for (int k = 0; k < 4; k++) begin
      chk("word_addr", 128'(rd_addr_q[k]), 128'(20'(base + 20'(4 * k))));
      exp_line[32*k +: 32] = rd_data_q[k];
    end
    chk("line_data", line, exp_line);
    repeat (3) @(negedge clk);
    chk("idle_after", 128'(busy), 128'd0);
    chk("no_extra_rd", 128'(rd_addr_q.size()), 128'd4);
    chk("one_ready", 128'(dr_cnt - dr0), 128'd1);
  endtask

  initial begin
    logic [19:0] la_prev;
    int dr0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ready", 128'(dr), 128'd0);
    chk("rst_line", line, 128'd0);
    chk("rst_line_addr", 128'(line_addr), 128'd0);
    chk("rst_mem_rd", 128'(mem_if.mem_rd_o), 128'd0);
    chk("rst_mem_addr", 128'(mem_if.mem_addr_o), 128'd0);
    rsn = 1'b1;
    @(negedge clk);

    run_fill(20'h01234, 1, 1'b0);
    run_fill(20'hFFFFC, 3, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_fill(20'($urandom), $urandom_range(1, 4), (i % 3) == 0);
    end

    // Asynchronous reset while waiting on the third word.
    start_req(20'h0ABC8, 3);
    wait_reads(3);
    @(negedge clk);
    #2 rsn = 1'b0;
    #1;
    chk("amid_busy", 128'(busy), 128'd0);
    chk("amid_ready", 128'(dr), 128'd0);
    chk("amid_line", line, 128'd0);
    chk("amid_line_addr", 128'(line_addr), 128'd0);
    chk("amid_mem_rd", 128'(mem_if.mem_rd_o), 128'd0);
    chk("amid_mem_addr", 128'(mem_if.mem_addr_o), 128'd0);
    @(negedge clk);
    rsn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_rd", 128'(rd_addr_q.size()), 128'd3);
    run_fill(20'h3C0D5, 2, 1'b0);

    // Cancel in WAIT of beat 1; data arrives two cycles later and is drained.
    la_prev = line_addr;
    dr0 = dr_cnt;
    start_req(20'h77770, 3);
    wait_reads(2);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("drain_busy", 128'(busy), 128'd1);
    @(negedge clk);
    chk("drain_busy2", 128'(busy), 128'd1);
    @(negedge clk);
    chk("drain_done", 128'(busy), 128'd0);
    repeat (5) @(negedge clk);
    chk("cancel_rd", 128'(rd_addr_q.size()), 128'd2);
    chk("cancel_ready", 128'(dr_cnt - dr0), 128'd0);
    chk("cancel_line_addr", 128'(line_addr), 128'(la_prev));
    run_fill(20'h12345, 1, 1'b0);

    // Cancel coincident with the last word's data.
    la_prev = line_addr;
    dr0 = dr_cnt;
    start_req(20'h5A5A0, 2);
    wait_reads(4);
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("late_cancel_idle", 128'(busy), 128'd0);
    repeat (4) @(negedge clk);
    chk("late_cancel_ready", 128'(dr_cnt - dr0), 128'd0);
    chk("late_cancel_line_addr", 128'(line_addr), 128'(la_prev));
    chk("late_cancel_rd", 128'(rd_addr_q.size()), 128'd4);

    // Requests while busy are dropped, not queued.
    run_fill(20'h4D2E8, 1, 1'b1);
    run_fill(20'hC0FFE, 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
